// File: rtl/lane_striping_distributor_pkg.sv
// Shared definitions for the lane striping distributor: default sizes,
// link-width encodings, pad symbol and the group FSM state type.
package lane_striping_distributor_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_LANES  = 4;
  localparam logic [7:0]  DEF_PAD_SYM    = 8'h00;

  // link_width encodings: active lanes = 2**link_width
  localparam logic [2:0] LW_X1 = 3'd0;
  localparam logic [2:0] LW_X2 = 3'd1;
  localparam logic [2:0] LW_X4 = 3'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/lane_striping_distributor_lane_group_counter.sv
// Lane pointer, active-lane latch and group completion / flush decision
// for the lane striping distributor.
module lane_striping_distributor_lane_group_counter
  import lane_striping_distributor_pkg::*;
#(
  parameter int unsigned MAX_LANES = DEF_MAX_LANES,
  localparam int unsigned IDX_W    = $clog2(MAX_LANES),
  localparam int unsigned NACT_W   = IDX_W + 1,
  localparam int unsigned LW_W     = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [LW_W-1:0]   link_width_i,
  output logic [IDX_W-1:0]  ptr_o,
  output logic [NACT_W-1:0] nact_c,
  output logic [NACT_W-1:0] fill_c,
  output logic              emit_c,
  output logic              busy_o,
  output logic              width_err_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NACT_W-1:0]   nact_q, nact_d;
  logic                werr_q, werr_d;
  logic                lw_rsv_c;

  // Next-state: width is re-latched only between groups, so an IDLE byte sees the new width.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    nact_d   = nact_q;
    werr_d   = werr_q;
    lw_rsv_c = link_width_i > LW_W'(IDX_W);

    if (state_q == ST_IDLE) begin
      nact_d = lw_rsv_c ? NACT_W'(1) : (NACT_W'(1) << link_width_i);
      werr_d = lw_rsv_c;
    end

    fill_c = NACT_W'(ptr_q) + NACT_W'(valid_i);
    emit_c = (fill_c == nact_d) || (flush_i && (fill_c != '0));
    ptr_d  = emit_c ? '0 : IDX_W'(fill_c);

    state_d = (ptr_d == '0) ? ST_IDLE : ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      nact_q  <= NACT_W'(1);
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      nact_q  <= nact_d;
      werr_q  <= werr_d;
    end
  end

  assign nact_c      = nact_d;
  assign ptr_o       = ptr_q;
  assign busy_o      = (state_q == ST_FILL);
  assign width_err_o = werr_q;

endmodule

// File: rtl/lane_striping_distributor.sv
// Stripes a byte stream round-robin across the active lanes and presents each
// completed (or flushed and padded) group to the lane encoders in one registered cycle.
module lane_striping_distributor
  import lane_striping_distributor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LANES            = DEF_MAX_LANES,
  parameter logic [DATA_WIDTH-1:0] PAD_SYM    = DATA_WIDTH'(DEF_PAD_SYM),
  localparam int unsigned IDX_W               = $clog2(MAX_LANES),
  localparam int unsigned NACT_W              = IDX_W + 1,
  localparam int unsigned LW_W                = IDX_W + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            valid_in,
  input  logic [LW_W-1:0]                 link_width,
  input  logic                            flush_in,
  output logic [MAX_LANES*DATA_WIDTH-1:0] lane_data,
  output logic [MAX_LANES-1:0]            lane_valid,
  output logic                            busy,
  output logic                            width_err
);

  logic [IDX_W-1:0]                ptr;
  logic [NACT_W-1:0]               nact_c;
  logic [NACT_W-1:0]               fill_c;
  logic                            emit_c;

  logic [DATA_WIDTH-1:0]           hold_q [MAX_LANES];
  logic [DATA_WIDTH-1:0]           hold_d [MAX_LANES];
  logic [MAX_LANES*DATA_WIDTH-1:0] lane_data_q, lane_data_d;
  logic [MAX_LANES-1:0]            lane_valid_q, lane_valid_d;

  lane_striping_distributor_lane_group_counter #(
    .MAX_LANES (MAX_LANES)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_in),
    .flush_i      (flush_in),
    .link_width_i (link_width),
    .ptr_o        (ptr),
    .nact_c       (nact_c),
    .fill_c       (fill_c),
    .emit_c       (emit_c),
    .busy_o       (busy),
    .width_err_o  (width_err)
  );

  // Holding regs and output assembly; the closing byte bypasses straight from din via hold_d.
  always_comb begin
    hold_d       = hold_q;
    lane_data_d  = lane_data_q;
    lane_valid_d = '0;

    if (valid_in) begin
      hold_d[ptr] = din;
    end

    if (emit_c) begin
      for (int i = 0; i < int'(MAX_LANES); i++) begin
        if (NACT_W'(i) < nact_c) begin
          lane_valid_d[i] = 1'b1;
          lane_data_d[i*DATA_WIDTH +: DATA_WIDTH] = (NACT_W'(i) < fill_c) ? hold_d[i] : PAD_SYM;
        end else begin
          lane_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '{default: '0};
      lane_data_q  <= '0;
      lane_valid_q <= '0;
    end else begin
      hold_q       <= hold_d;
      lane_data_q  <= lane_data_d;
      lane_valid_q <= lane_valid_d;
    end
  end

  assign lane_data  = lane_data_q;
  assign lane_valid = lane_valid_q;

endmodule

// File: tb/tb_lane_striping_distributor.sv
// Bench for lane_striping_distributor: directed scenarios plus random traffic,
// compared every cycle against a queue-based group model.
module tb_lane_striping_distributor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        valid_in;
  logic [2:0]  link_width;
  logic        flush_in;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic        busy;
  logic        width_err;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0]  m_grp[$];
  int          m_nact = 1;
  logic [31:0] m_data = '0;
  logic [3:0]  m_valid = '0;
  logic        m_werr = 1'b0;

  logic [37:0] act_v, exp_v;

  always #5 clk = ~clk;

  lane_striping_distributor dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .valid_in   (valid_in),
    .link_width (link_width),
    .flush_in   (flush_in),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy),
    .width_err  (width_err)
  );

  // Drive one cycle of inputs, advance one edge, update the group model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                       input logic [2:0] lw, input logic f);
    int w;
    reset = r; valid_in = v; din = d; link_width = lw; flush_in = f;
    @(posedge clk);
    #1;
    if (r) begin
      m_grp.delete();
      m_nact = 1; m_data = '0; m_valid = '0; m_werr = 1'b0;
    end else begin
      m_valid = '0;
      if (m_grp.size() == 0) begin
        w = 1 << lw;
        if (w > 4) begin m_nact = 1; m_werr = 1'b1; end
        else       begin m_nact = w; m_werr = 1'b0; end
      end
      if (v) m_grp.push_back(d);
      if (m_grp.size() == m_nact || (f && m_grp.size() > 0)) begin
        m_data = '0;
        for (int i = 0; i < m_nact; i++)
          m_data[i*8 +: 8] = (i < m_grp.size()) ? m_grp[i] : 8'h00;
        m_valid = 4'((1 << m_nact) - 1);
        m_grp.delete();
      end
    end
    exp_v = {m_data, m_valid, (m_grp.size() > 0), m_werr};
    act_v = {lane_data, lane_valid, busy, width_err};
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 8'hAA, 3'd2, 1'b0);
      total++;
      if (act_v !== 38'h0) begin
        bad++; $display("FAIL reset act=%h exp=%h", act_v, 38'h0);
      end
    end
  endtask

  task automatic test_x4_stripe();
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b1, 8'(k), 3'd2, 1'b0);
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL x4_model byte=%0d act=%h exp=%h", k, act_v, exp_v);
      end
      if (k == 4 || k == 8) begin
        total++;
        if (lane_data !== ((k == 4) ? 32'h04030201 : 32'h08070605) || lane_valid !== 4'hF) begin
          bad++; $display("FAIL x4_group k=%0d act=%h/%h", k, lane_data, lane_valid);
        end
      end else begin
        total++;
        if (busy !== 1'b1 || lane_valid !== 4'h0) begin
          bad++; $display("FAIL x4_busy k=%0d busy=%b valid=%h exp busy=1 valid=0", k, busy, lane_valid);
        end
      end
    end
  endtask

  task automatic test_x2_x1();
    logic [7:0] b[3];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, b[k], 3'd1, 1'b0);
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL x2_model k=%0d act=%h exp=%h", k, act_v, exp_v);
      end
      if (k == 1) begin
        total++;
        if (lane_data !== 32'h00002211 || lane_valid !== 4'h3) begin
          bad++; $display("FAIL x2_group act=%h/%h exp=00002211/3", lane_data, lane_valid);
        end
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL x2_hold busy=%b exp=1", busy);
    end
    cycle(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    total++;
    if (act_v !== exp_v || lane_data !== 32'h00000033 || lane_valid !== 4'h3) begin
      bad++; $display("FAIL x2_flush act=%h exp=%h", act_v, exp_v);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 8'(8'h44 + 8'(k) * 8'h11), 3'd0, 1'b0);
      total++;
      if (act_v !== exp_v || lane_valid !== 4'h1) begin
        bad++; $display("FAIL x1_emit k=%0d act=%h exp=%h", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 8'hA1, 3'd2, 1'b0);
    cycle(1'b0, 1'b1, 8'hA2, 3'd2, 1'b0);
    cycle(1'b0, 1'b1, 8'hA3, 3'd2, 1'b1);
    total++;
    if (act_v !== exp_v || lane_data !== 32'h00A3A2A1 || lane_valid !== 4'hF) begin
      bad++; $display("FAIL flush_pad act=%h exp=%h", act_v, exp_v);
    end
    cycle(1'b0, 1'b0, 8'h00, 3'd2, 1'b1);
    total++;
    if (act_v !== exp_v || lane_valid !== 4'h0) begin
      bad++; $display("FAIL flush_empty act=%h exp=%h", act_v, exp_v);
    end
  endtask

  task automatic test_width_change();
    logic [2:0] lws[8];
    lws = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b1, 8'(8'hC0 + 8'(k)), lws[k], 1'b0);
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL wchg_model k=%0d act=%h exp=%h", k, act_v, exp_v);
      end
      if (k == 3 || k == 5) begin
        total++;
        if (lane_valid !== ((k == 3) ? 4'hF : 4'h3)) begin
          bad++; $display("FAIL wchg_valid k=%0d act=%h", k, lane_valid);
        end
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 3'd3, 1'b0);
    total++;
    if (act_v !== exp_v || width_err !== 1'b1) begin
      bad++; $display("FAIL width_err act=%h exp=%h", act_v, exp_v);
    end
    cycle(1'b0, 1'b1, 8'h5A, 3'd3, 1'b0);
    total++;
    if (act_v !== exp_v || lane_valid !== 4'h1 || lane_data !== 32'h0000005A) begin
      bad++; $display("FAIL width_err_x1 act=%h exp=%h", act_v, exp_v);
    end
    cycle(1'b0, 1'b0, 8'h00, 3'd2, 1'b0);
    total++;
    if (act_v !== exp_v || width_err !== 1'b0) begin
      bad++; $display("FAIL width_err_clr act=%h exp=%h", act_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_group();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'(8'hE0 + 8'(k)), 3'd2, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 3'd2, 1'b0);
    total++;
    if (act_v !== 38'h0) begin
      bad++; $display("FAIL rst_mid act=%h exp=0", act_v);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 8'(8'hB0 + 8'(k)), 3'd2, 1'b0);
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL rst_mid_model k=%0d act=%h exp=%h", k, act_v, exp_v);
      end
    end
    total++;
    if (lane_data !== 32'hB3B2B1B0 || lane_valid !== 4'hF) begin
      bad++; $display("FAIL rst_mid_group act=%h/%h exp=b3b2b1b0/f", lane_data, lane_valid);
    end
  endtask

  task automatic test_random();
    logic       r, v, f;
    logic [2:0] lw;
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 75);
      f  = ($urandom_range(0, 99) < 10);
      lw = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cycle(r, v, 8'($urandom), lw, f);
      total++;
      if (act_v !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d act=%h exp=%h", k, act_v, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; valid_in = 1'b0; link_width = 3'd0; flush_in = 1'b0;
    test_reset();
    test_x4_stripe();
    test_x2_x1();
    test_flush();
    test_width_change();
    test_reset_mid_group();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
